l2_instr_mem_responder: RTL and testbench
=========================================

Name: l2_instr_mem_responder

Overview:
- Stub L2 instruction memory that sits on the common instruction bus.
- Responder end of the I-cache miss-fill protocol: the cache wins arbitration and drives the block address on Address_Com. This block latches that address, waits a fixed access latency, then drives the instruction word on Data_Bus_Com and asserts Data_in_Bus.
- It holds the response until the arbiter removes the grant.

Parameters:
- MEM_ADDR_BITS, 10: word-address width; memory depth = 2^MEM_ADDR_BITS words of 32 bits.
- LATENCY, 4: edges from first sampled grant to response; legal range 1..15.
- DATA_SEED, 32'hA5A50000: memory init pattern, mem[i] = (i<<2) ^ DATA_SEED.

Ports:
- clk  input  1: system clock, rising edge.
- rst  input  1: reset; asynchronous, active-high.
- Com_Bus_Gnt  input  1: OR of all arbiter grants on the instruction common bus.
- Address_Com  input  32: block address from the granted requester ({tag, index, 2'b00}).
- Data_Bus_Com  inout  32: common data bus; driven only in RESP, else 32'hZ.
- Data_in_Bus  inout  1: data-valid strobe; driven 1'b1 only in RESP, else 1'bZ. Bench supplies a pull-down.
- L2_busy  output  1: high in any state other than IDLE.
- L2_resp_cnt  output  16: count of completed responses, saturating at 16'hFFFF.

Behaviour:
- Reset (async, rst=1): state=IDLE, L2_busy=0, L2_resp_cnt=0, Data_Bus_Com=Z, Data_in_Bus=Z, addr_reg=0, cnt=0, resp_data=0. Memory contents are not reset; initialised once at time 0 with the DATA_SEED pattern.
- States: IDLE, CAPTURE, WAIT, RESP. All transitions occur on the rising edge of clk.
- IDLE: if Com_Bus_Gnt=1, go to CAPTURE. The requester drives Address_Com on the edge where it samples the grant, so the address is not valid until the next edge.
- CAPTURE:
  - If Com_Bus_Gnt=0, go to IDLE (abort).
  - Else addr_reg <= Address_Com; resp_data <= mem[Address_Com[MEM_ADDR_BITS+1:2]]. Upper address bits above MEM_ADDR_BITS+1 are ignored, so the memory wraps.
  - If LATENCY==1, go to RESP; else cnt <= LATENCY-1 and go to WAIT.
- WAIT:
  - If Com_Bus_Gnt=0, go to IDLE; nothing is driven, the counter is not incremented, resp_data is discarded.
  - Else if cnt==1, go to RESP; else cnt <= cnt-1.
- RESP:
  - Data_Bus_Com=resp_data and Data_in_Bus=1, both driven combinationally from the state.
  - Stay in RESP while Com_Bus_Gnt=1.
  - On the first edge with Com_Bus_Gnt=0: go to IDLE, release both buses to Z, and increment L2_resp_cnt (saturating).
- Latency: if N is the first edge sampling Com_Bus_Gnt=1, Data_in_Bus is high after edge N+LATENCY. Address_Com is sampled at edge N+1.
- Back-to-back transactions: a grant still or again high in IDLE immediately starts a new transaction. At least one IDLE cycle separates two responses.
- Address changes while in WAIT or RESP are ignored; the captured address wins.
- rst asserted mid-transaction: buses go to Z immediately (asynchronously) and the state returns to IDLE.
- Read-only: no write path.

Optional Feature:
- Macro L2_ADDR_ERR_EN.
- Defined:
  - Adds output L2_addr_err (1 bit, reset 0).
  - At CAPTURE, if any Address_Com bit above MEM_ADDR_BITS+1 is 1, or Address_Com[1:0]!=0, the address is erroneous: resp_data <= 32'hDEADBEEF and L2_addr_err is high for the duration of RESP.
  - L2_resp_cnt still increments on completion.
- Undefined: no L2_addr_err port; the upper address bits wrap silently and the low bits are ignored.

Test Plan:
- Reset check: rst=1 mid-RESP -> Data_Bus_Com=Z and Data_in_Bus=Z without waiting for a clock edge; L2_busy=0; L2_resp_cnt=0.
- Basic fill, LATENCY=4: Gnt rises before edge N, Address_Com=32'h00000010 from edge N -> Data_in_Bus=1 after edge N+4; Data_Bus_Com=32'hA5A50010. After Gnt drops: Z on both buses, L2_resp_cnt=1.
- LATENCY=1: same stimulus -> Data_in_Bus=1 after edge N+1.
- Abort: Gnt drops during WAIT -> Data_in_Bus never asserts; L2_resp_cnt unchanged; next grant with address 32'h00000FFC -> data 32'hA5A50FFC.
- Wrap, feature off, MEM_ADDR_BITS=10: address 32'h00001010 -> data 32'hA5A50010.
- Error, L2_ADDR_ERR_EN defined: address 32'h00001010 -> data 32'hDEADBEEF and L2_addr_err=1 during RESP; address 32'h00000012 -> same error response.

Source files
------------

// File: rtl/l2_instr_mem_responder.sv
// rtl/l2_instr_mem_responder.sv - stub L2 instruction memory answering I-cache miss fills
//
// Purpose: after a grant on the instruction common bus, latches the block address,
// waits LATENCY edges, then drives the instruction word plus a valid strobe until
// the grant is removed. Read-only; contents follow mem[i] = (i << 2) ^ DATA_SEED.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   Com_Bus_Gnt   OR of all arbiter grants on the common bus
//   Address_Com   block address from the granted requester
//   Data_Bus_Com  common data bus, driven only while responding, else Z
//   Data_in_Bus   data-valid strobe, driven 1 only while responding, else Z
//   L2_busy       high whenever not idle
//   L2_resp_cnt   completed responses, saturating at 16'hFFFF
//   L2_addr_err   (only with L2_ADDR_ERR_EN) erroneous address flag during response
//
// Optional feature macro: L2_ADDR_ERR_EN

module l2_instr_mem_responder #(
  parameter int          MEM_ADDR_BITS = 10,
  parameter int          LATENCY       = 4,
  parameter logic [31:0] DATA_SEED     = 32'hA5A50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Com_Bus_Gnt,
  input  logic [31:0] Address_Com,
  inout  wire  [31:0] Data_Bus_Com,
  inout  wire         Data_in_Bus,
  output logic        L2_busy,
`ifdef L2_ADDR_ERR_EN
  output logic        L2_addr_err,
`endif
  output logic [15:0] L2_resp_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_WAIT    = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] addr_reg_q;
  logic [31:0] resp_data_q;
  logic [3:0]  cnt_q;
  logic [15:0] resp_cnt_q;

  // The memory is never written, so its contents are a pure function of the
  // word index; compute the word instead of storing an array.
  logic [MEM_ADDR_BITS-1:0] word_idx;
  logic [31:0]              rom_word_d;

  assign word_idx   = Address_Com[MEM_ADDR_BITS+1:2];
  assign rom_word_d = (32'(word_idx) << 2) ^ DATA_SEED;

`ifdef L2_ADDR_ERR_EN
  logic addr_err_d;
  logic addr_err_q;

  // Erroneous when bits beyond the memory span are set or the address is not word aligned.
  assign addr_err_d = ((Address_Com >> (MEM_ADDR_BITS + 2)) != 32'd0) ||
                      (Address_Com[1:0] != 2'b00);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_reg_q  <= 32'd0;
      resp_data_q <= 32'd0;
      cnt_q       <= 4'd0;
      resp_cnt_q  <= 16'd0;
`ifdef L2_ADDR_ERR_EN
      addr_err_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // The requester only presents its address one edge after seeing the grant.
          if (Com_Bus_Gnt) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (!Com_Bus_Gnt) begin
            state_q <= S_IDLE;
          end else begin
            addr_reg_q  <= Address_Com;
            resp_data_q <= rom_word_d;
`ifdef L2_ADDR_ERR_EN
            addr_err_q  <= addr_err_d;
            if (addr_err_d) resp_data_q <= 32'hDEADBEEF;
`endif
            if (LATENCY == 1) begin
              state_q <= S_RESP;
            end else begin
              cnt_q   <= 4'(LATENCY - 1);
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!Com_Bus_Gnt) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          // Completion is counted when the arbiter takes the grant away.
          if (!Com_Bus_Gnt) begin
            state_q <= S_IDLE;
            if (resp_cnt_q != 16'hFFFF) resp_cnt_q <= resp_cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bus drivers decode the state directly so an asynchronous reset releases them at once.
  assign Data_Bus_Com = (state_q == S_RESP) ? resp_data_q : 32'hZZZZ_ZZZZ;
  assign Data_in_Bus  = (state_q == S_RESP) ? 1'b1 : 1'bZ;
  assign L2_busy      = (state_q != S_IDLE);
  assign L2_resp_cnt  = resp_cnt_q;

`ifdef L2_ADDR_ERR_EN
  assign L2_addr_err  = addr_err_q && (state_q == S_RESP);
`endif

  // The captured address is kept for observability only.
  logic unused_addr_reg;
  assign unused_addr_reg = ^addr_reg_q;

endmodule

// File: tb/tb_l2_instr_mem_responder.sv
// tb/tb_l2_instr_mem_responder.sv - scoreboard bench for l2_instr_mem_responder

module tb_l2_instr_mem_responder;

  localparam logic [31:0] SEED = 32'hA5A50000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gnt0 = 1'b0;
  logic        gnt1 = 1'b0;
  logic [31:0] addr0 = 32'd0;
  logic [31:0] addr1 = 32'd0;
  tri0  [31:0] bus0;
  tri0  [31:0] bus1;
  tri0         vld0;
  tri0         vld1;
  logic        busy0, busy1;
  logic [15:0] cnt0, cnt1;
`ifdef L2_ADDR_ERR_EN
  logic        err0, err1;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          exp_cnt0 = 0;
  int          exp_cnt1 = 0;

  always #5 clk = ~clk;

  l2_instr_mem_responder #(.MEM_ADDR_BITS(10), .LATENCY(4), .DATA_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .Com_Bus_Gnt(gnt0), .Address_Com(addr0),
    .Data_Bus_Com(bus0), .Data_in_Bus(vld0), .L2_busy(busy0),
`ifdef L2_ADDR_ERR_EN
    .L2_addr_err(err0),
`endif
    .L2_resp_cnt(cnt0)
  );

  l2_instr_mem_responder #(.MEM_ADDR_BITS(10), .LATENCY(1), .DATA_SEED(SEED)) dut1 (
    .clk(clk), .rst(rst), .Com_Bus_Gnt(gnt1), .Address_Com(addr1),
    .Data_Bus_Com(bus1), .Data_in_Bus(vld1), .L2_busy(busy1),
`ifdef L2_ADDR_ERR_EN
    .L2_addr_err(err1),
`endif
    .L2_resp_cnt(cnt1)
  );

  function automatic logic model_err(input logic [31:0] a);
`ifdef L2_ADDR_ERR_EN
    return (a[31:12] != 20'd0) || (a[1:0] != 2'b00);
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] a);
    if (model_err(a)) return 32'hDEADBEEF;
    return {20'd0, a[11:2], 2'b00} ^ SEED;
  endfunction

  function automatic logic get_vld(input bit sel);
    return sel ? vld1 : vld0;
  endfunction

  function automatic logic [31:0] get_bus(input bit sel);
    return sel ? bus1 : bus0;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy0;
  endfunction

  function automatic logic [15:0] get_cnt(input bit sel);
    return sel ? cnt1 : cnt0;
  endfunction

  task automatic set_gnt(input bit sel, input logic v);
    if (sel) gnt1 = v; else gnt0 = v;
  endtask

  task automatic set_addr(input bit sel, input logic [31:0] a);
    if (sel) addr1 = a; else addr0 = a;
  endtask

  // One full fill: grant, address one edge later, wait for the strobe, hold, release.
  task automatic run_txn(input bit sel, input logic [31:0] addr, input int exp_lat,
                         input int hold, input bit late_change);
    int          k;
    logic [31:0] exp;
    @(negedge clk); set_gnt(sel, 1'b1);
    @(posedge clk); #1 set_addr(sel, addr);
    exp_q.push_back(model_data(addr));
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k == 1 && late_change) set_addr(sel, ~addr);
      if (get_vld(sel) === 1'b1) break;
    end
    n_checks++;
    if (k != exp_lat) begin
      n_fail++; $display("FAIL latency sel=%0d: got %0d edges, expected %0d", sel, k, exp_lat);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (get_bus(sel) !== exp) begin
      n_fail++; $display("FAIL resp_data sel=%0d addr=%h: got %h, expected %h", sel, addr, get_bus(sel), exp);
    end
    n_checks++;
    if (get_busy(sel) !== 1'b1) begin
      n_fail++; $display("FAIL busy_resp sel=%0d: got %b, expected 1", sel, get_busy(sel));
    end
`ifdef L2_ADDR_ERR_EN
    n_checks++;
    if ((sel ? err1 : err0) !== model_err(addr)) begin
      n_fail++; $display("FAIL addr_err sel=%0d addr=%h: got %b, expected %b", sel, addr, sel ? err1 : err0, model_err(addr));
    end
`endif
    repeat (hold) @(posedge clk);
    #1;
    n_checks++;
    if (get_vld(sel) !== 1'b1 || get_bus(sel) !== exp) begin
      n_fail++; $display("FAIL resp_hold sel=%0d: got vld=%b data=%h, expected 1 %h", sel, get_vld(sel), get_bus(sel), exp);
    end
    @(negedge clk); set_gnt(sel, 1'b0);
    @(posedge clk); #1;
    if (sel) exp_cnt1++; else exp_cnt0++;
    n_checks++;
    if (get_vld(sel) !== 1'b0 || get_bus(sel) !== 32'd0 || get_busy(sel) !== 1'b0) begin
      n_fail++; $display("FAIL release sel=%0d: got vld=%b data=%h busy=%b, expected 0 0 0", sel, get_vld(sel), get_bus(sel), get_busy(sel));
    end
    n_checks++;
    if (get_cnt(sel) !== 16'(sel ? exp_cnt1 : exp_cnt0)) begin
      n_fail++; $display("FAIL resp_cnt sel=%0d: got %0d, expected %0d", sel, get_cnt(sel), sel ? exp_cnt1 : exp_cnt0);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (busy0 !== 1'b0 || cnt0 !== 16'd0 || vld0 !== 1'b0 || bus0 !== 32'd0) begin
      n_fail++; $display("FAIL reset_state: got busy=%b cnt=%0d vld=%b data=%h, expected 0 0 0 0", busy0, cnt0, vld0, bus0);
    end
    n_checks++;
    if (busy1 !== 1'b0 || cnt1 !== 16'd0 || vld1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_state_lat1: got busy=%b cnt=%0d vld=%b, expected 0 0 0", busy1, cnt1, vld1);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    run_txn(1'b0, 32'h00000010, 4, 2, 1'b0);
  endtask

  task automatic test_latency1();
    run_txn(1'b1, 32'h00000010, 1, 1, 1'b0);
    run_txn(1'b1, 32'h00000FFC, 1, 0, 1'b0);
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    @(negedge clk); gnt0 = 1'b1;
    @(posedge clk); #1 addr0 = 32'h00000020;
    @(posedge clk);
    @(posedge clk); #1;
    n_checks++;
    if (busy0 !== 1'b1) begin
      n_fail++; $display("FAIL busy_wait: got %b, expected 1", busy0);
    end
    @(negedge clk); gnt0 = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (vld0 === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen || busy0 !== 1'b0 || cnt0 !== 16'(exp_cnt0)) begin
      n_fail++; $display("FAIL abort: got strobe_seen=%b busy=%b cnt=%0d, expected 0 0 %0d", seen, busy0, cnt0, exp_cnt0);
    end
    run_txn(1'b0, 32'h00000FFC, 4, 1, 1'b0);
  endtask

  task automatic test_wrap_and_err();
    run_txn(1'b0, 32'h00001010, 4, 1, 1'b0);
    run_txn(1'b0, 32'h00000012, 4, 1, 1'b0);
  endtask

  task automatic test_addr_hold();
    run_txn(1'b0, 32'h00000344, 4, 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = (i % 2 == 0) ? ($urandom() & 32'h00000FFC) : $urandom();
      run_txn(1'b0, a, 4, i % 3, 1'b0);
    end
  endtask

  task automatic test_reset_mid_resp();
    int k = 0;
    @(negedge clk); gnt0 = 1'b1;
    @(posedge clk); #1 addr0 = 32'h00000040;
    while (k < 20 && vld0 !== 1'b1) begin
      @(posedge clk); #1; k++;
    end
    n_checks++;
    if (vld0 !== 1'b1) begin
      n_fail++; $display("FAIL reach_resp: got vld=%b after %0d edges, expected 1", vld0, k);
    end
    #2 rst = 1'b1;
    #1;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    n_checks++;
    if (vld0 !== 1'b0 || bus0 !== 32'd0) begin
      n_fail++; $display("FAIL async_release: got vld=%b data=%h, expected 0 0", vld0, bus0);
    end
    n_checks++;
    if (busy0 !== 1'b0 || cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      n_fail++; $display("FAIL async_reset_state: got busy=%b cnt0=%0d cnt1=%0d, expected 0 0 0", busy0, cnt0, cnt1);
    end
    @(negedge clk); gnt0 = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_txn(1'b0, 32'h00000010, 4, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency1();
    test_abort();
    test_wrap_and_err();
    test_addr_hold();
    test_back_to_back();
    test_reset_mid_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
